keypoint_reader: RTL and testbench

Reads detected keypoints back out of the two keypoint SRAMs filled by the detect/filter stage and streams them, one coordinate per beat, to the downstream orientation/descriptor stage over a valid/ready interface. Layer 1 (DoG pair 0) is fully drained before layer 2 (DoG pair 1). The block sits between the keypoint SRAM read ports and the descriptor pipeline. It starts on a `start` pulse from the system controller and reports completion with a one-cycle `done` pulse.

---
 rtl/keypoint_reader.sv | 189 ++++++++++++++++++
 tb/tb_keypoint_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypoint_reader.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// keypoint_reader
// Drains layer-1 then layer-2 keypoint SRAMs into a valid/ready beat stream.
// Rev 1.0
// =============================================================================
module keypoint_reader #(
  parameter int ADDR_W = 11,
  parameter int KP_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   keypoint_1_count,
  input  logic [ADDR_W:0]   keypoint_2_count,
  output logic              keypoint_1_re,
  output logic [ADDR_W-1:0] keypoint_1_addr,
  input  logic [KP_W-1:0]   keypoint_1_dout,
  output logic              keypoint_2_re,
  output logic [ADDR_W-1:0] keypoint_2_addr,
  input  logic [KP_W-1:0]   keypoint_2_dout,
  output logic              kp_valid,
  input  logic              kp_ready,
  output logic [KP_W-11:0]  kp_row,
  output logic [9:0]        kp_col,
  output logic              kp_layer,
  output logic              kp_last,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = 10;
  localparam int CNT_W = ADDR_W + 1;
  localparam int ENT_W = KP_W + 2;
  localparam logic [CNT_W-1:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ1  = 3'd1,
    S_READ2  = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [CNT_W-1:0]  clamp1, clamp2, last1, last2;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              infl_layer_q, infl_layer_d;
  logic              infl_last_q, infl_last_d;
  logic [ENT_W-1:0]  mem_q [2];
  logic [ENT_W-1:0]  mem_d [2];
  logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]        fifo_count_q, fifo_count_d;

  logic              push, pop, issue, issue_last;
  logic              at_last1, at_last2, credit_ok, drained;
  logic [2:0]        occ;
  logic [ENT_W-1:0]  push_data, head;

  always_comb begin
    clamp1    = (keypoint_1_count > MAX_COUNT) ? MAX_COUNT : keypoint_1_count;
    clamp2    = (keypoint_2_count > MAX_COUNT) ? MAX_COUNT : keypoint_2_count;
    last1     = cnt1_q - ONE;
    last2     = cnt2_q - ONE;
    at_last1  = ({1'b0, addr_q} == last1);
    at_last2  = ({1'b0, addr_q} == last2);
    pop       = (fifo_count_q != 2'd0) && kp_ready;
    push      = inflight_q;
    // Buffered plus in-flight entries after this cycle's pop; a read may
    // issue only while that leaves room for its data in the 2-entry FIFO.
    occ       = {1'b0, fifo_count_q} + {2'b0, inflight_q} - {2'b0, pop};
    credit_ok = (occ < 3'd2);
    drained   = (occ == 3'd0);
  end

  always_comb begin
    state_d      = state_q;
    cnt1_d       = cnt1_q;
    cnt2_d       = cnt2_q;
    addr_d       = addr_q;
    issue        = 1'b0;
    issue_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt1_d = clamp1;
          cnt2_d = clamp2;
          addr_d = '0;
          // An empty pass goes through DRAIN so done lands two cycles out.
          if (clamp1 != '0)      state_d = S_READ1;
          else if (clamp2 != '0) state_d = S_READ2;
          else                   state_d = S_DRAIN;
        end
      end
      S_READ1: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = at_last1 && (cnt2_q == '0);
          if (at_last1) begin
            addr_d  = '0;
            state_d = (cnt2_q != '0) ? S_READ2 : S_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_READ2: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_last = at_last2;
          if (at_last2) begin
            addr_d  = '0;
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drained) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d   = issue;
    infl_layer_d = (state_q == S_READ2);
    infl_last_d  = issue_last;
    push_data    = {infl_layer_q, infl_last_q,
                    infl_layer_q ? keypoint_2_dout : keypoint_1_dout};
    mem_d[0]     = mem_q[0];
    mem_d[1]     = mem_q[1];
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    fifo_count_d = fifo_count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt1_q       <= '0;
      cnt2_q       <= '0;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      infl_layer_q <= 1'b0;
      infl_last_q  <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      fifo_count_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt1_q       <= cnt1_d;
      cnt2_q       <= cnt2_d;
      addr_q       <= addr_d;
      inflight_q   <= inflight_d;
      infl_layer_q <= infl_layer_d;
      infl_last_q  <= infl_last_d;
      mem_q[0]     <= mem_d[0];
      mem_q[1]     <= mem_d[1];
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign kp_valid        = (fifo_count_q != 2'd0);
  assign kp_layer        = kp_valid & head[ENT_W-1];
  assign kp_last         = kp_valid & head[ENT_W-2];
  assign kp_row          = kp_valid ? head[KP_W-1:COL_W] : '0;
  assign kp_col          = kp_valid ? head[COL_W-1:0] : '0;
  assign keypoint_1_re   = issue && (state_q == S_READ1);
  assign keypoint_2_re   = issue && (state_q == S_READ2);
  assign keypoint_1_addr = addr_q;
  assign keypoint_2_addr = addr_q;
  assign busy            = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done            = (state_q == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_keypoint_reader.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_keypoint_reader
// Directed self-checking bench with SRAM models for both keypoint layers.
// Rev 1.0
// =============================================================================
module tb_keypoint_reader;

  logic        clk = 1'b0;
  logic        rst, start, kp_ready;
  logic [11:0] keypoint_1_count, keypoint_2_count;
  logic        keypoint_1_re, keypoint_2_re;
  logic [10:0] keypoint_1_addr, keypoint_2_addr;
  logic [18:0] keypoint_1_dout, keypoint_2_dout;
  logic        kp_valid, kp_layer, kp_last, busy, done;
  logic [8:0]  kp_row;
  logic [9:0]  kp_col;

  always #5 clk = ~clk;

  keypoint_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .keypoint_1_count(keypoint_1_count), .keypoint_2_count(keypoint_2_count),
    .keypoint_1_re(keypoint_1_re), .keypoint_1_addr(keypoint_1_addr),
    .keypoint_1_dout(keypoint_1_dout),
    .keypoint_2_re(keypoint_2_re), .keypoint_2_addr(keypoint_2_addr),
    .keypoint_2_dout(keypoint_2_dout),
    .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_row(kp_row), .kp_col(kp_col),
    .kp_layer(kp_layer), .kp_last(kp_last), .busy(busy), .done(done)
  );

  logic [18:0] mem1 [2048];
  logic [18:0] mem2 [2048];

  always @(posedge clk) begin
    if (keypoint_1_re) keypoint_1_dout <= mem1[keypoint_1_addr];
    if (keypoint_2_re) keypoint_2_dout <= mem2[keypoint_2_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic st, input logic rdy, input logic rs);
    @(negedge clk);
    start    = st;
    kp_ready = rdy;
    rst      = rs;
    #1;
  endtask

  // Per-pass observations
  logic [20:0] bq [$];
  int nbeats, data_err, addr_err, stab_err, both_re, re1_cnt, re2_cnt;
  int first_re, first_valid, last_cyc, last_cnt, last_idx;
  int first_done, done_cnt, busy_err, max_out;

  function automatic logic [20:0] exp_beat(input int idx, input int n1, input int tot);
    logic lst;
    lst = (idx == tot - 1);
    if (idx >= tot)    return 21'h1FFFFF;
    else if (idx < n1) return {1'b0, lst, mem1[idx]};
    else               return {1'b1, lst, mem2[idx - n1]};
  endfunction

  task automatic run_pass(input int c1, input int c2, input logic [3:0] pat,
                          input int start2_cyc, input int max_cyc);
    int n1, n2, tot, a1, a2, issued, accepted;
    logic pv, pr;
    logic [20:0] pd, cur;
    n1 = (c1 > 2048) ? 2048 : c1;
    n2 = (c2 > 2048) ? 2048 : c2;
    tot = n1 + n2;
    a1 = 0; a2 = 0; issued = 0; accepted = 0;
    pv = 1'b0; pr = 1'b0; pd = '0;
    bq.delete();
    nbeats = 0; data_err = 0; addr_err = 0; stab_err = 0; both_re = 0;
    re1_cnt = 0; re2_cnt = 0; first_re = -1; first_valid = -1; last_cyc = -1;
    last_cnt = 0; last_idx = -1; first_done = -1; done_cnt = 0; busy_err = 0;
    max_out = 0;
    keypoint_1_count = 12'(c1);
    keypoint_2_count = 12'(c2);
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (cyc == start2_cyc) begin
        keypoint_1_count = 12'd7;
        keypoint_2_count = 12'd7;
      end
      tick((cyc == 0) || (cyc == start2_cyc), pat[cyc % 4], 1'b0);
      cur = {kp_layer, kp_last, kp_row, kp_col};
      if (keypoint_1_re && keypoint_2_re) both_re++;
      if (keypoint_1_re) begin
        if (int'(keypoint_1_addr) != a1) addr_err++;
        a1++; re1_cnt++; issued++;
        if (first_re < 0) first_re = cyc;
      end
      if (keypoint_2_re) begin
        if (int'(keypoint_2_addr) != a2) addr_err++;
        a2++; re2_cnt++; issued++;
        if (first_re < 0) first_re = cyc;
      end
      if (pv && !pr && (!kp_valid || cur != pd)) stab_err++;
      if (kp_valid && first_valid < 0) first_valid = cyc;
      if (kp_valid && kp_ready) begin
        if (cur != exp_beat(nbeats, n1, tot)) data_err++;
        bq.push_back(cur);
        if (kp_last) begin
          last_cnt++;
          last_idx = nbeats;
        end
        last_cyc = cyc;
        nbeats++;
        accepted++;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
        if (busy) busy_err++;
      end
      pv = kp_valid; pr = kp_ready; pd = cur;
      if (first_done >= 0 && cyc >= first_done + 3) break;
    end
    check("pass_completes", 32'(first_done >= 0), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem1[i] = 19'((i * 613 + 7) & 32'h7FFFF);
      mem2[i] = 19'((i * 1237 + 32'h30000) & 32'h7FFFF);
    end
    mem1[0] = 19'h00001;
    mem1[1] = 19'h00402;
    mem1[2] = 19'h7FFFF;
    rst = 1'b1; start = 1'b0; kp_ready = 1'b1;
    keypoint_1_count = '0; keypoint_2_count = '0;

    // Reset state
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check("rst_re", {30'd0, keypoint_1_re, keypoint_2_re}, 32'd0);
    check("rst_addr", {10'd0, keypoint_1_addr, keypoint_2_addr}, 32'd0);
    check("rst_kp", {11'd0, kp_valid, kp_layer, kp_last, kp_row, kp_col}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);

    // Basic pass, crossing the layer boundary
    run_pass(3, 2, 4'b1111, -1, 40);
    check("basic_beats", nbeats, 5);
    check("basic_data", data_err, 0);
    check("basic_first_re", first_re, 1);
    check("basic_first_valid", first_valid, 3);
    check("basic_last_beat_cyc", last_cyc, 7);
    if (nbeats == 5) begin
      check("basic_layers", {bq[0][20], bq[1][20], bq[2][20], bq[3][20], bq[4][20]}, 32'b00011);
      check("basic_beat3_row", bq[2][18:10], 32'd511);
      check("basic_beat3_col", bq[2][9:0], 32'd1023);
      check("basic_beat2_rowcol", {bq[1][18:10], bq[1][9:0]}, {9'd1, 10'd2});
    end
    check("basic_last_cnt", last_cnt, 1);
    check("basic_last_idx", last_idx, 4);
    check("basic_done_cyc", first_done, 8);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_busy_at_done", busy_err, 0);
    check("basic_one_re", both_re, 0);

    // Backpressure, ready pattern 1,0,0,1,...
    run_pass(4, 0, 4'b1001, -1, 60);
    check("bp_beats", nbeats, 4);
    check("bp_data", data_err, 0);
    check("bp_stable", stab_err, 0);
    check("bp_max_out_le2", 32'(max_out <= 2), 32'd1);
    check("bp_last_idx", last_idx, 3);
    check("bp_done_cnt", done_cnt, 1);

    // Backpressure across the layer boundary
    run_pass(3, 3, 4'b0100, -1, 80);
    check("bp2_beats", nbeats, 6);
    check("bp2_data", data_err, 0);
    check("bp2_stable", stab_err, 0);
    check("bp2_max_out_le2", 32'(max_out <= 2), 32'd1);

    // Empty layer 1
    run_pass(0, 2, 4'b1111, -1, 40);
    check("e1_beats", nbeats, 2);
    check("e1_no_re1", re1_cnt, 0);
    check("e1_data", data_err, 0);
    check("e1_first_valid", first_valid, 3);

    // Both layers empty
    run_pass(0, 0, 4'b1111, -1, 20);
    check("e0_beats", nbeats, 0);
    check("e0_no_re", re1_cnt + re2_cnt, 0);
    check("e0_done_cyc", first_done, 2);
    check("e0_done_cnt", done_cnt, 1);

    // Full layer, then an over-range count that clamps
    run_pass(2048, 0, 4'b1111, -1, 2100);
    check("full_beats", nbeats, 2048);
    check("full_re1", re1_cnt, 2048);
    check("full_addr", addr_err, 0);
    check("full_data", data_err, 0);
    check("full_last_idx", last_idx, 2047);
    check("full_done_cyc", first_done, 2051);
    run_pass(3000, 0, 4'b1111, -1, 2100);
    check("clamp_beats", nbeats, 2048);
    check("clamp_addr", addr_err, 0);
    check("clamp_data", data_err, 0);
    check("clamp_done_cyc", first_done, 2051);

    // Start while busy
    run_pass(4, 2, 4'b1111, 3, 40);
    check("sb_beats", nbeats, 6);
    check("sb_data", data_err, 0);
    check("sb_addr", addr_err, 0);
    check("sb_done_cnt", done_cnt, 1);

    // Reset mid-pass after two beats
    keypoint_1_count = 12'd4;
    keypoint_2_count = 12'd2;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("mr_beat1_valid", {31'd0, kp_valid}, 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    check("mr_beat2_valid", {31'd0, kp_valid}, 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    check("mr_re", {30'd0, keypoint_1_re, keypoint_2_re}, 32'd0);
    check("mr_addr", {10'd0, keypoint_1_addr, keypoint_2_addr}, 32'd0);
    check("mr_kp", {11'd0, kp_valid, kp_layer, kp_last, kp_row, kp_col}, 32'd0);
    check("mr_busy_done", {30'd0, busy, done}, 32'd0);
    begin
      int late_done;
      late_done = 0;
      for (int i = 0; i < 10; i++) begin
        tick(1'b0, 1'b1, 1'b0);
        if (done || kp_valid) late_done++;
      end
      check("mr_no_done", late_done, 0);
    end
    run_pass(4, 2, 4'b1111, -1, 40);
    check("mr_replay_beats", nbeats, 6);
    check("mr_replay_addr", addr_err, 0);
    check("mr_replay_data", data_err, 0);
    check("mr_replay_first_valid", first_valid, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
